// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the digital-clock command parser: field widths,
// command mode codes, ASCII byte values, commit range limits, reset defaults,
// parser FSM state encoding and small character/range helper functions.
// -----------------------------------------------------------------------------
package clock_pkg;

    // Decimal accumulator width: 4 digits (max 9999) always fit in 14 bits
    localparam int ACC_W     = 14;
    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;
    localparam int DAY_W     = 5;
    localparam int MONTH_W   = 4;
    localparam int YEAR_W    = 12;
    localparam int DMODE_W   = 2;
    localparam int MAX_ARGS  = 6;
    localparam int ARG_IDX_W = 3;

    // Command mode codes (value of the first token of a command)
    localparam logic [ACC_W-1:0] MODE_12H   = 14'd1;
    localparam logic [ACC_W-1:0] MODE_24H   = 14'd2;
    localparam logic [ACC_W-1:0] MODE_SET   = 14'd3;
    localparam logic [ACC_W-1:0] MODE_ALARM = 14'd4;
    localparam logic [ACC_W-1:0] MODE_TIMER = 14'd5;

    // ASCII byte values
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    // Commit range limits
    localparam logic [ACC_W-1:0] HOUR_MAX  = 14'd23;
    localparam logic [ACC_W-1:0] MIN_MAX   = 14'd59;
    localparam logic [ACC_W-1:0] DAY_MIN   = 14'd1;
    localparam logic [ACC_W-1:0] DAY_MAX   = 14'd31;
    localparam logic [ACC_W-1:0] MONTH_MIN = 14'd1;
    localparam logic [ACC_W-1:0] MONTH_MAX = 14'd12;
    localparam logic [ACC_W-1:0] YEAR_MAX  = 14'd4095;

    // Reset defaults
    localparam int                 YEAR_RST_DEF = 2020;
    localparam logic [DAY_W-1:0]   DAY_RST      = 5'd1;
    localparam logic [MONTH_W-1:0] MONTH_RST    = 4'd1;
    localparam logic [DMODE_W-1:0] DMODE_RST    = 2'd2;

    // Parser FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,  // gap before a mode token
        ST_MODE_TOK = 3'd1,  // inside the mode token
        ST_ARG_GAP  = 3'd2,  // gap before an argument token
        ST_ARG_TOK  = 3'd3,  // inside an argument token
        ST_SKIP     = 3'd4   // discarding the rest of a bad line
    } parse_state_t;

    // Token separator: space, TAB, CR or LF
    function automatic logic is_sep(input logic [7:0] ch);
        return (ch == ASCII_SP) || (ch == ASCII_TAB) ||
               (ch == ASCII_CR) || (ch == ASCII_LF);
    endfunction

    // Index of the final argument for a mode that takes arguments
    function automatic logic [ARG_IDX_W-1:0] last_arg_idx(input logic [ACC_W-1:0] mode);
        case (mode)
            MODE_SET:   return 3'd5;
            MODE_ALARM: return 3'd2;
            MODE_TIMER: return 3'd1;
            default:    return 3'd0;
        endcase
    endfunction

    // Inclusive range test used for fields with a non-zero lower bound
    function automatic logic in_range(input logic [ACC_W-1:0] v,
                                      input logic [ACC_W-1:0] lo,
                                      input logic [ACC_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/ascii_dec_accum.sv
// -----------------------------------------------------------------------------
// ascii_dec_accum
// Classifies each incoming ASCII byte and accumulates a decimal token.
//   clk, reset     : clock, synchronous active-low reset
//   in_valid       : byte accepted this cycle
//   in_byte        : ASCII byte
//   clr            : discard the current token on an accepted byte
//   is_digit       : in_byte is '0'..'9'
//   is_gap         : in_byte is a separator (space, TAB, CR, LF)
//   too_long       : in_byte is a digit that would exceed MAX_DIGITS
//   value          : decimal value of the digits accepted so far
// Any accepted non-digit byte ends the token and clears the accumulator, so
// value always holds the token just completed when its separator arrives.
// -----------------------------------------------------------------------------
module ascii_dec_accum
    import clock_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    input  logic             clr,
    output logic             is_digit,
    output logic             is_gap,
    output logic             too_long,
    output logic [ACC_W-1:0] value
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [CNT_W-1:0] count;
    logic [3:0]       digit_val;

    // Byte classification and over-length detection
    always_comb begin
        is_digit  = (in_byte >= ASCII_0) && (in_byte <= ASCII_9);
        is_gap    = is_sep(in_byte);
        digit_val = in_byte[3:0];  // low nibble of '0'..'9' is the digit value
        too_long  = is_digit && (count == CNT_W'(MAX_DIGITS));
    end

    // Token accumulator: value = value*10 + digit, cleared on token end
    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= '0;
            count <= '0;
        end else if (in_valid) begin
            if (clr || !is_digit || too_long) begin
                value <= '0;
                count <= '0;
            end else begin
                value <= (value << 3) + (value << 1) + {{(ACC_W-4){1'b0}}, digit_val};
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_cmd_parser.sv
// -----------------------------------------------------------------------------
// clock_cmd_parser
// Decodes an ASCII stream of whitespace-separated decimal tokens into
// digital_clock controls. A command is a mode token followed by its args:
//   1/2 -> display mode (12 h / 24 h), 3 -> h m s D M Y, 4 -> alarm h m s,
//   5 -> timer m s. Arguments are buffered and committed all-or-nothing.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   rx_valid, rx_data, rx_ready: byte stream handshake (always ready)
//   alarm_clr, timer_clr       : level clears of alarm_enable / timer_start
//   set_*, set_load            : time/date load values and one-cycle strobe
//   alarm_*, alarm_enable      : alarm time and enable level
//   timer_*, timer_start       : timer value and start level
//   display_mode               : 1 = 12 h, 2 = 24 h
//   cmd_err                    : one-cycle strobe, command rejected
// -----------------------------------------------------------------------------
module clock_cmd_parser
    import clock_pkg::*;
#(
    parameter int YEAR_RST   = YEAR_RST_DEF,
    parameter int MAX_DIGITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    input  logic               alarm_clr,
    input  logic               timer_clr,
    output logic [HOUR_W-1:0]  set_hour,
    output logic [MIN_W-1:0]   set_min,
    output logic [MIN_W-1:0]   set_sec,
    output logic [DAY_W-1:0]   set_day,
    output logic [MONTH_W-1:0] set_month,
    output logic [YEAR_W-1:0]  set_year,
    output logic               set_load,
    output logic [HOUR_W-1:0]  alarm_hour,
    output logic [MIN_W-1:0]   alarm_min,
    output logic [MIN_W-1:0]   alarm_sec,
    output logic               alarm_enable,
    output logic [MIN_W-1:0]   timer_min,
    output logic [MIN_W-1:0]   timer_sec,
    output logic               timer_start,
    output logic [DMODE_W-1:0] display_mode,
    output logic               cmd_err
);

    parse_state_t           state, next_state;
    logic                   byte_acc, is_digit, is_gap, is_lf, too_long;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       mode_r;
    logic [ARG_IDX_W-1:0]   arg_idx_r;
    logic [ACC_W-1:0]       args_r [MAX_ARGS];
    logic [ACC_W-1:0]       fin    [MAX_ARGS];
    logic                   last_arg, args_ok, commit_s;
    logic                   err_s, disp_commit_s, mode_latch_s, store_arg_s;
    logic                   set_commit_s, alarm_commit_s, timer_commit_s;

    ascii_dec_accum #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_accum (
        .clk      (clk),
        .reset    (reset),
        .in_valid (byte_acc),
        .in_byte  (rx_data),
        .clr      (state == ST_SKIP),
        .is_digit (is_digit),
        .is_gap   (is_gap),
        .too_long (too_long),
        .value    (acc)
    );

    // Parser state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Per-byte event decode: errors, mode latch, argument store, commits
    always_comb begin
        byte_acc = rx_valid && rx_ready;
        is_lf    = (rx_data == ASCII_LF);
        last_arg = (arg_idx_r == last_arg_idx(mode_r));
        // Argument set as it will be once the current token is stored
        for (int i = 0; i < MAX_ARGS; i++) begin
            fin[i] = (i == int'(arg_idx_r)) ? acc : args_r[i];
        end
        case (mode_r)
            MODE_SET:   args_ok = (fin[0] <= HOUR_MAX) && (fin[1] <= MIN_MAX) &&
                                  (fin[2] <= MIN_MAX) && in_range(fin[3], DAY_MIN, DAY_MAX) &&
                                  in_range(fin[4], MONTH_MIN, MONTH_MAX) && (fin[5] <= YEAR_MAX);
            MODE_ALARM: args_ok = (fin[0] <= HOUR_MAX) && (fin[1] <= MIN_MAX) && (fin[2] <= MIN_MAX);
            MODE_TIMER: args_ok = (fin[0] <= MIN_MAX) && (fin[1] <= MIN_MAX);
            default:    args_ok = 1'b0;
        endcase

        err_s         = 1'b0;
        disp_commit_s = 1'b0;
        mode_latch_s  = 1'b0;
        store_arg_s   = 1'b0;
        commit_s      = 1'b0;
        if (byte_acc) begin
            case (state)
                ST_IDLE, ST_ARG_GAP: begin
                    err_s = !is_digit && !is_gap;
                end
                ST_MODE_TOK: begin
                    if (is_digit) begin
                        err_s = too_long;
                    end else if (is_gap) begin
                        if ((acc == MODE_12H) || (acc == MODE_24H)) begin
                            disp_commit_s = 1'b1;
                        end else if ((acc >= MODE_SET) && (acc <= MODE_TIMER)) begin
                            mode_latch_s = 1'b1;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        err_s = 1'b1;
                    end
                end
                ST_ARG_TOK: begin
                    if (is_digit) begin
                        err_s = too_long;
                    end else if (is_gap) begin
                        if (!last_arg) begin
                            store_arg_s = 1'b1;
                        end else if (args_ok) begin
                            commit_s = 1'b1;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        err_s = 1'b1;
                    end
                end
                ST_SKIP: begin
                    err_s = 1'b0;
                end
                default: begin
                    err_s = 1'b0;
                end
            endcase
        end else begin
            err_s = 1'b0;
        end
        set_commit_s   = commit_s && (mode_r == MODE_SET);
        alarm_commit_s = commit_s && (mode_r == MODE_ALARM);
        timer_commit_s = commit_s && (mode_r == MODE_TIMER);
    end

    // Next-state logic; an error on LF resynchronises immediately
    always_comb begin
        next_state = state;
        if (!byte_acc) begin
            next_state = state;
        end else if (err_s) begin
            next_state = is_lf ? ST_IDLE : ST_SKIP;
        end else begin
            case (state)
                ST_IDLE:     next_state = is_digit ? ST_MODE_TOK : ST_IDLE;
                ST_MODE_TOK: next_state = is_digit ? ST_MODE_TOK :
                                          (mode_latch_s ? ST_ARG_GAP : ST_IDLE);
                ST_ARG_GAP:  next_state = is_digit ? ST_ARG_TOK : ST_ARG_GAP;
                ST_ARG_TOK:  next_state = is_digit ? ST_ARG_TOK :
                                          (store_arg_s ? ST_ARG_GAP : ST_IDLE);
                ST_SKIP:     next_state = is_lf ? ST_IDLE : ST_SKIP;
                default:     next_state = ST_IDLE;
            endcase
        end
    end

    // Argument buffer and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_r       <= '0;
            arg_idx_r    <= '0;
            for (int i = 0; i < MAX_ARGS; i++) begin
                args_r[i] <= '0;
            end
            rx_ready     <= 1'b1;
            set_hour     <= '0;
            set_min      <= '0;
            set_sec      <= '0;
            set_day      <= DAY_RST;
            set_month    <= MONTH_RST;
            set_year     <= YEAR_W'(YEAR_RST);
            set_load     <= 1'b0;
            alarm_hour   <= '0;
            alarm_min    <= '0;
            alarm_sec    <= '0;
            alarm_enable <= 1'b0;
            timer_min    <= '0;
            timer_sec    <= '0;
            timer_start  <= 1'b0;
            display_mode <= DMODE_RST;
            cmd_err      <= 1'b0;
        end else begin
            rx_ready <= 1'b1;
            set_load <= set_commit_s;
            cmd_err  <= err_s;
            if (mode_latch_s) begin
                mode_r    <= acc;
                arg_idx_r <= '0;
            end else if (store_arg_s) begin
                args_r[arg_idx_r] <= acc;
                arg_idx_r         <= arg_idx_r + 1'b1;
            end
            if (disp_commit_s) begin
                display_mode <= acc[DMODE_W-1:0];
            end
            if (set_commit_s) begin
                set_hour  <= fin[0][HOUR_W-1:0];
                set_min   <= fin[1][MIN_W-1:0];
                set_sec   <= fin[2][MIN_W-1:0];
                set_day   <= fin[3][DAY_W-1:0];
                set_month <= fin[4][MONTH_W-1:0];
                set_year  <= fin[5][YEAR_W-1:0];
            end
            // A commit in the same cycle as a clear keeps the level set
            if (alarm_commit_s) begin
                alarm_hour   <= fin[0][HOUR_W-1:0];
                alarm_min    <= fin[1][MIN_W-1:0];
                alarm_sec    <= fin[2][MIN_W-1:0];
                alarm_enable <= 1'b1;
            end else if (alarm_clr) begin
                alarm_enable <= 1'b0;
            end
            if (timer_commit_s) begin
                timer_min   <= fin[0][MIN_W-1:0];
                timer_sec   <= fin[1][MIN_W-1:0];
                timer_start <= 1'b1;
            end else if (timer_clr) begin
                timer_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_clock_cmd_parser
// Scoreboard bench: the driver feeds bytes/clears into a token-list reference
// model and queues the expected output snapshot; a monitor pops and compares
// one snapshot for every accepted byte or clear request seen on the bus.
// -----------------------------------------------------------------------------
module tb_clock_cmd_parser;

    localparam int YEAR_RST   = 2020;
    localparam int MAX_DIGITS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       alarm_clr = 1'b0;
    logic       timer_clr = 1'b0;
    logic       rx_ready;
    logic [4:0] set_hour, set_day, alarm_hour;
    logic [5:0] set_min, set_sec, alarm_min, alarm_sec, timer_min, timer_sec;
    logic [3:0] set_month;
    logic [11:0] set_year;
    logic       set_load, alarm_enable, timer_start, cmd_err;
    logic [1:0] display_mode;

    clock_cmd_parser #(.YEAR_RST(YEAR_RST), .MAX_DIGITS(MAX_DIGITS)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .alarm_clr(alarm_clr), .timer_clr(timer_clr),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .set_load(set_load), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_sec(alarm_sec), .alarm_enable(alarm_enable),
        .timer_min(timer_min), .timer_sec(timer_sec), .timer_start(timer_start),
        .display_mode(display_mode), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] sh; logic [5:0] sm; logic [5:0] ss; logic [4:0] sd;
        logic [3:0] smo; logic [11:0] sy; logic ld;
        logic [4:0] ah; logic [5:0] am; logic [5:0] asec; logic ae;
        logic [5:0] tm; logic [5:0] ts; logic tst;
        logic [1:0] dm; logic err; logic rdy;
    } snap_t;

    snap_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model state: committed outputs plus the pending command
    int m_sh, m_sm, m_ss, m_sd, m_smo, m_sy, m_ah, m_am, m_asec, m_tm, m_ts, m_dm;
    bit m_ae, m_tst;
    int toks[$];
    int cur_val, cur_len;
    bit in_tok, skipping;

    function automatic void model_reset();
        m_sh = 0; m_sm = 0; m_ss = 0; m_sd = 1; m_smo = 1; m_sy = YEAR_RST;
        m_ah = 0; m_am = 0; m_asec = 0; m_ae = 1'b0;
        m_tm = 0; m_ts = 0; m_tst = 1'b0; m_dm = 2;
        toks.delete(); cur_val = 0; cur_len = 0; in_tok = 1'b0; skipping = 1'b0;
    endfunction

    function automatic snap_t model_snap(input bit ld, input bit err);
        snap_t s;
        s.sh = 5'(m_sh); s.sm = 6'(m_sm); s.ss = 6'(m_ss); s.sd = 5'(m_sd);
        s.smo = 4'(m_smo); s.sy = 12'(m_sy); s.ld = ld;
        s.ah = 5'(m_ah); s.am = 6'(m_am); s.asec = 6'(m_asec); s.ae = m_ae;
        s.tm = 6'(m_tm); s.ts = 6'(m_ts); s.tst = m_tst;
        s.dm = 2'(m_dm); s.err = err; s.rdy = 1'b1;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.sh = set_hour; s.sm = set_min; s.ss = set_sec; s.sd = set_day;
        s.smo = set_month; s.sy = set_year; s.ld = set_load;
        s.ah = alarm_hour; s.am = alarm_min; s.asec = alarm_sec; s.ae = alarm_enable;
        s.tm = timer_min; s.ts = timer_sec; s.tst = timer_start;
        s.dm = display_mode; s.err = cmd_err; s.rdy = rx_ready;
        return s;
    endfunction

    // One bus cycle through the model: completed command -> commit or reject
    function automatic snap_t model_step(input bit v, input logic [7:0] b,
                                         input bit aclr, input bit tclr);
        bit err, load, a_com, t_com, sep;
        int mode, need;
        err = 1'b0; load = 1'b0; a_com = 1'b0; t_com = 1'b0;
        sep = (b == 8'h20) || (b == 8'h09) || (b == 8'h0D) || (b == 8'h0A);
        if (v) begin
            if (skipping) begin
                if (b == 8'h0A) skipping = 1'b0;
            end else if (b >= 8'h30 && b <= 8'h39) begin
                if (cur_len == MAX_DIGITS) err = 1'b1;
                else begin
                    cur_val = cur_val * 10 + int'(b) - 48;
                    cur_len++;
                    in_tok = 1'b1;
                end
            end else if (sep) begin
                if (in_tok) begin
                    toks.push_back(cur_val);
                    in_tok = 1'b0; cur_val = 0; cur_len = 0;
                    mode = toks[0];
                    case (mode)
                        1, 2: need = 0;
                        3: need = 6;
                        4: need = 3;
                        5: need = 2;
                        default: need = -1;
                    endcase
                    if (need < 0) err = 1'b1;
                    else if (toks.size() == need + 1) begin
                        if (mode <= 2) m_dm = mode;
                        else if (mode == 3) begin
                            if (toks[1] <= 23 && toks[2] <= 59 && toks[3] <= 59 &&
                                toks[4] >= 1 && toks[4] <= 31 && toks[5] >= 1 &&
                                toks[5] <= 12 && toks[6] <= 4095) begin
                                m_sh = toks[1]; m_sm = toks[2]; m_ss = toks[3];
                                m_sd = toks[4]; m_smo = toks[5]; m_sy = toks[6];
                                load = 1'b1;
                            end else err = 1'b1;
                        end else if (mode == 4) begin
                            if (toks[1] <= 23 && toks[2] <= 59 && toks[3] <= 59) begin
                                m_ah = toks[1]; m_am = toks[2]; m_asec = toks[3];
                                m_ae = 1'b1; a_com = 1'b1;
                            end else err = 1'b1;
                        end else begin
                            if (toks[1] <= 59 && toks[2] <= 59) begin
                                m_tm = toks[1]; m_ts = toks[2];
                                m_tst = 1'b1; t_com = 1'b1;
                            end else err = 1'b1;
                        end
                        toks.delete();
                    end
                end
            end else err = 1'b1;
            if (err) begin
                toks.delete(); in_tok = 1'b0; cur_val = 0; cur_len = 0;
                skipping = (b != 8'h0A);
            end
        end
        if (aclr && !a_com) m_ae = 1'b0;
        if (tclr && !t_com) m_tst = 1'b0;
        return model_snap(load, err);
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expectation
    task automatic drive(input bit v, input logic [7:0] b, input bit aclr, input bit tclr);
        @(negedge clk);
        rx_valid = v; rx_data = b; alarm_clr = aclr; timer_clr = tclr;
        if (v || aclr || tclr) exp_q.push_back(model_step(v, b, aclr, tclr));
    endtask

    task automatic send_b(input logic [7:0] b, input bit rnd);
        if (rnd && $urandom_range(0, 7) == 0) drive(1'b0, 8'($urandom), 1'b0, 1'b0);
        drive(1'b1, b, rnd && ($urandom_range(0, 15) == 0), rnd && ($urandom_range(0, 15) == 0));
    endtask

    task automatic send_str(input string s, input bit rnd);
        for (int i = 0; i < s.len(); i++) send_b(s[i], rnd);
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Let the monitor drain, then pulse reset and check the reset snapshot
    task automatic do_reset();
        snap_t got, e;
        idle();
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_before_reset: %0d expectations left, required 0", exp_q.size());
            exp_q.delete();
        end
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        e = model_snap(1'b0, 1'b0);
        got = dut_snap();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_values: got %h required %h", got, e);
        end
        reset = 1'b1;
    endtask

    function automatic string sep_str();
        case ($urandom_range(0, 9))
            0: return "\t";
            1: return "\r";
            2: return "\n";
            3: return "  ";
            default: return " ";
        endcase
    endfunction

    function automatic string num_str(input int hi);
        int v;
        string t;
        case ($urandom_range(0, 19))
            0: v = $urandom_range(0, 9999);
            1: return $sformatf("%05d", $urandom_range(0, 99999));
            default: v = $urandom_range(0, hi + 2);
        endcase
        t = $sformatf("%0d", v);
        while (t.len() < 4 && $urandom_range(0, 3) == 0) t = {"0", t};
        return t;
    endfunction

    task automatic rand_cmd();
        int sel, mode;
        int lim[$];
        string s;
        sel = $urandom_range(0, 19);
        if (sel < 3) mode = 1;
        else if (sel < 5) mode = 2;
        else if (sel < 10) mode = 3;
        else if (sel < 14) mode = 4;
        else if (sel < 18) mode = 5;
        else mode = (sel == 18) ? 0 : 7;
        case (mode)
            3: lim = '{23, 59, 59, 31, 12, 4095};
            4: lim = '{23, 59, 59};
            5: lim = '{59, 59};
            1, 2: lim = '{};
            default: lim = '{9, 9};
        endcase
        s = $sformatf("%0d", mode);
        foreach (lim[k]) s = {s, sep_str(), num_str(lim[k])};
        s = {s, sep_str()};
        if ($urandom_range(0, 19) == 0) s = {s, "z "};
        send_str(s, 1'b1);
    endtask

    // Monitor: one comparison per accepted byte or clear request
    initial begin : monitor
        bit hit;
        snap_t got, e;
        forever begin
            @(posedge clk);
            hit = reset && ((rx_valid && rx_ready) || alarm_clr || timer_clr);
            @(negedge clk);
            if (hit) begin
                vectors++;
                got = dut_snap();
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_txn: got %h with no expectation queued", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL outputs @%0t: got %h required %h", $time, got, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL timeout: run exceeded time limit (%0d vectors, %0d miscompares)", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        snap_t got, e;
        model_reset();
        repeat (3) @(negedge clk);
        e = model_snap(1'b0, 1'b0);
        got = dut_snap();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL initial_reset: got %h required %h", got, e);
        end
        reset = 1'b1;

        send_str("3 12 30 00 15 08 2024\n", 1'b0);
        send_str("4 7 0 5 ", 1'b0);
        idle();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        send_str("5 1\n30 ", 1'b0);
        do_reset();
        send_str("3 24 00 00 1 1 2020\n", 1'b0);
        send_str("9 x 1\n1 ", 1'b0);
        send_str("4 1 2", 1'b0);
        do_reset();
        send_str(" ", 1'b0);
        // Boundaries, over-length tokens, commit racing a clear
        send_str("3 23 59 59 31 12 4095\r\n", 1'b0);
        send_str("3 0 0 0 0 1 1\n3 1 1 1 1 13 1\n3 1 1 1 1 1 4096\n", 1'b0);
        send_str("12345 2\n0002\t", 1'b0);
        send_str("5 2 3", 1'b0);
        drive(1'b1, 8'h20, 1'b0, 1'b1);
        send_str("4 23 59 5", 1'b0);
        drive(1'b1, 8'h0A, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        send_str("5 60 0 ", 1'b0);

        for (int n = 0; n < 300; n++) begin
            rand_cmd();
            if (n % 100 == 50) do_reset();
        end
        send_str("\n", 1'b0);
        idle();
        idle();
        idle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_cmd_parser.md
# clock_cmd_parser

Hardware command decoder for the digital clock: consumes an ASCII byte stream of whitespace-separated decimal tokens (mode code followed by arguments) and produces the set/alarm/timer/display controls that `digital_clock` consumes. It is the receiving end of the mode-command format the bench drives from `input.txt`. It sits between a UART receiver and `digital_clock`, replacing file-driven stimulus on silicon.

## Interface
- `YEAR_RST`, 2020: reset value of `set_year`
- `MAX_DIGITS`, 4: maximum digits per token
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-low
- `rx_valid`  in  1  byte present on `rx_data`
- `rx_data`  in  8  ASCII byte
- `rx_ready`  out  1  byte accepted when `rx_valid && rx_ready`; constant 1 out of reset
- `alarm_clr`, `timer_clr`  in  1  level-clear requests for `alarm_enable` / `timer_start`
- `set_hour` out 5, `set_min`/`set_sec` out 6, `set_day` out 5, `set_month` out 4, `set_year` out 12: time/date load values
- `set_load`  out  1  one-cycle strobe, new time/date valid
- `alarm_hour` out 5, `alarm_min`/`alarm_sec` out 6; `alarm_enable` out 1 level
- `timer_min`/`timer_sec` out 6; `timer_start` out 1 level
- `display_mode`  out  2  1 = 12 h, 2 = 24 h
- `cmd_err`  out  1  one-cycle strobe, command rejected

## Operation
- Tokens: digits `0`–`9`; separators: space, TAB, CR, LF (any run of separators = one gap). Commands may span lines.
- Modes: 1/2 → `display_mode` ← mode, no args; 3 → 6 args (h m s D M Y); 4 → 3 args (h m s), sets `alarm_enable`; 5 → 2 args (m s), sets `timer_start`.
- FSM states: IDLE (gap before mode), MODE_TOK, ARG_GAP, ARG_TOK, SKIP.
  - IDLE: digit → MODE_TOK; separator → stay; other → error.
  - MODE_TOK: digit accumulates; separator → mode 1/2 commit → IDLE, mode 3/4/5 → ARG_GAP, else error.
  - ARG_GAP: digit → ARG_TOK; separator → stay.
  - ARG_TOK: separator stores arg; last arg → range check, commit or error → IDLE; otherwise → ARG_GAP.
  - Error (any state): non-digit non-separator, digit count > `MAX_DIGITS`, bad mode, range fail → `cmd_err` pulse; go to SKIP unless the error byte is LF (then IDLE).
  - SKIP: discard until LF → IDLE.
- Accumulator: 14 bits, acc ← acc·10 + digit; with ≤4 digits it never overflows.
- Range checks at commit: hour ≤ 23, min/sec ≤ 59, day 1–31, month 1–12, year ≤ 4095; timer min/sec ≤ 59. Any failure → no outputs change, `cmd_err`.
- Commit is all-or-nothing; args buffered internally until final token.
- `alarm_clr` clears `alarm_enable`, `timer_clr` clears `timer_start`; same-cycle commit of mode 4/5 wins over clear.

## Timing
- Reset values: `set_*` 0:0:0, day 1, month 1, year `YEAR_RST`; alarm fields 0, `alarm_enable` 0; timer fields 0, `timer_start` 0; `display_mode` 2; `set_load`, `cmd_err` 0; state IDLE, `rx_ready` 1.
- Commit latency: outputs update on the edge accepting the terminating separator; `set_load`/`cmd_err` high for exactly the following cycle.
- Bytes with `rx_valid` low ignored; back-to-back bytes every cycle supported.
- Reset mid-command discards partial tokens; no strobe emitted.
- End of stream without trailing separator: command stays pending (no commit).

## Structure
- `clock_pkg`: field widths, mode codes (`MODE_12H`..`MODE_TIMER`), ASCII constants, range limits, reset defaults, FSM state enum.
- Sub-module `ascii_dec_accum`: digit detect, ×10 accumulate, digit-count and over-length flag, clear on gap.

## Test plan
- Stream `"3 12 30 00 15 08 2024\n"` → one `set_load` pulse; set_* = 12:30:00 15-08-2024; no `cmd_err`.
- `"4 7 0 5 "` then `alarm_clr` pulse → `alarm_enable` 1 after final space, 0 the cycle after clear; alarm = 07:00:05.
- `"5 1\n30 "` (split across LF) → `timer_min`=1, `timer_sec`=30, `timer_start`=1.
- `"3 24 00 00 1 1 2020\n"` → `cmd_err` pulse, set_* keep reset values, no `set_load`.
- `"9 x 1\n1 "` → `cmd_err` for mode 9, rest skipped to LF, then `display_mode`=1.
- `"4 1 2"` then reset low one cycle then `" "` → no commit, all outputs at reset values.
